sha256_id_buf: RTL and testbench

- Parameterised FIFO that buffers packet IDs from the SHA-256 ID issuer.
- Its upstream is the issuer's ID-buffer handshake port. Its downstream is the ID validator, which compares buffered IDs against IDs returned with hash results.
- Decouples ID issue from hash completion so several packets can be in flight. Preserves strict issue order and the per-beat last flag.

---
 rtl/sha256_id_buf.sv | 81 ++++++++
 tb/tb_sha256_id_buf.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sha256_id_buf.sv
// Order-preserving FIFO between the SHA-256 ID issuer and the ID validator.
// Each entry carries a packet ID plus its last flag; the head is presented without a bypass.
module sha256_id_buf #(
    parameter int DEPTH = 4,
    parameter int ID_W  = 6
) (
    input  logic                       clk,
    input  logic                       sync_rst,
    input  logic [ID_W-1:0]            id_in,
    input  logic                       id_in_last,
    input  logic                       id_in_valid,
    output logic                       id_in_ready,
    output logic [ID_W-1:0]            id_out,
    output logic                       id_out_last,
    output logic                       id_out_valid,
    input  logic                       id_out_ready,
    output logic [$clog2(DEPTH):0]     status_count,
    output logic                       status_full,
    output logic                       status_empty
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [ID_W:0]    mem_reg [DEPTH];
    logic [ID_W:0]    head;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;

    assign wr_idx = wr_ptr_reg[IDX_W-1:0];
    assign rd_idx = rd_ptr_reg[IDX_W-1:0];

    // The extra pointer MSB separates the full and empty cases when the index bits match.
    assign full  = (wr_ptr_reg[PTR_W-1] != rd_ptr_reg[PTR_W-1]) && (wr_idx == rd_idx);
    assign empty = (wr_ptr_reg == rd_ptr_reg);

    // Ready depends only on state, so a same-cycle pop never frees a slot for a push.
    assign push = id_in_valid && !full;
    assign pop  = id_out_ready && !empty;

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    // Storage has no reset; only the pointers define which entries are live.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (!sync_rst && push && (wr_idx == IDX_W'(gi))) begin
                    mem_reg[gi] <= {id_in_last, id_in};
                end
            end
        end
    endgenerate

    assign head = mem_reg[rd_idx];

    assign id_in_ready  = !full;
    assign id_out_valid = !empty;
    assign id_out       = empty ? '0 : head[ID_W-1:0];
    assign id_out_last  = empty ? 1'b0 : head[ID_W];
    assign status_count = wr_ptr_reg - rd_ptr_reg;
    assign status_full  = full;
    assign status_empty = empty;

endmodule

// File: tb/tb_sha256_id_buf.sv
// Directed self-checking bench for sha256_id_buf: reset, fill, drain, streaming wrap,
// minimum latency and reset in the middle of traffic.
module tb_sha256_id_buf;
    localparam int DEPTH = 4;
    localparam int ID_W  = 6;

    logic                   clk;
    logic                   sync_rst;
    logic [ID_W-1:0]        id_in;
    logic                   id_in_last;
    logic                   id_in_valid;
    logic                   id_in_ready;
    logic [ID_W-1:0]        id_out;
    logic                   id_out_last;
    logic                   id_out_valid;
    logic                   id_out_ready;
    logic [$clog2(DEPTH):0] status_count;
    logic                   status_full;
    logic                   status_empty;

    int n_checks;
    int n_errors;

    sha256_id_buf #(.DEPTH(DEPTH), .ID_W(ID_W)) dut (
        .clk          (clk),
        .sync_rst     (sync_rst),
        .id_in        (id_in),
        .id_in_last   (id_in_last),
        .id_in_valid  (id_in_valid),
        .id_in_ready  (id_in_ready),
        .id_out       (id_out),
        .id_out_last  (id_out_last),
        .id_out_valid (id_out_valid),
        .id_out_ready (id_out_ready),
        .status_count (status_count),
        .status_full  (status_full),
        .status_empty (status_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        sync_rst     = 1'b1;
        id_in        = '0;
        id_in_last   = 1'b0;
        id_in_valid  = 1'b0;
        id_out_ready = 1'b0;
        step();
        step();
        sync_rst = 1'b0;

        // Reset state
        check("rst_in_ready", int'(id_in_ready), 1);
        check("rst_out_valid", int'(id_out_valid), 0);
        check("rst_count", int'(status_count), 0);
        check("rst_empty", int'(status_empty), 1);
        check("rst_full", int'(status_full), 0);
        check("rst_id_out", int'(id_out), 0);
        check("rst_last", int'(id_out_last), 0);
        $display("reset: in_ready=%0d out_valid=%0d count=%0d", id_in_ready, id_out_valid, status_count);

        // Fill with 1..4, downstream stalled
        for (int i = 1; i <= 4; i++) begin
            id_in       = 6'(i);
            id_in_last  = 1'b1;
            id_in_valid = 1'b1;
            step();
            check("fill_count", int'(status_count), i);
            check("fill_head", int'(id_out), 1);
            $display("push id=%0d count=%0d", i, status_count);
        end
        check("fill_full", int'(status_full), 1);
        check("fill_in_ready", int'(id_in_ready), 0);
        id_in = 6'd5;
        step();
        check("ovf_count", int'(status_count), 4);
        check("ovf_head", int'(id_out), 1);
        check("ovf_head_last", int'(id_out_last), 1);
        $display("push id=5 refused count=%0d", status_count);
        id_in_valid = 1'b0;

        // Drain in order
        id_out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("drain_valid", int'(id_out_valid), 1);
            check("drain_id", int'(id_out), i);
            check("drain_last", int'(id_out_last), 1);
            $display("pop id=%0d last=%0d", id_out, id_out_last);
            step();
        end
        check("drain_valid_end", int'(id_out_valid), 0);
        check("drain_count_end", int'(status_count), 0);
        check("drain_id_zero", int'(id_out), 0);
        check("drain_empty", int'(status_empty), 1);

        // Streaming push+pop every cycle, IDs 0..63 then 0
        for (int k = 0; k <= 64; k++) begin
            id_in       = 6'(k);
            id_in_last  = k[0];
            id_in_valid = 1'b1;
            step();
            check("stream_count", int'(status_count), 1);
            check("stream_id", int'(id_out), k % 64);
            check("stream_last", int'(id_out_last), k % 2);
            $display("stream push=%0d head=%0d last=%0d", k % 64, id_out, id_out_last);
        end
        id_in_valid = 1'b0;
        step();
        check("stream_end_valid", int'(id_out_valid), 0);
        check("stream_end_count", int'(status_count), 0);

        // Minimum latency: push 0x2A into empty buffer with downstream ready
        id_in       = 6'h2A;
        id_in_last  = 1'b1;
        id_in_valid = 1'b1;
        step();
        id_in_valid = 1'b0;
        check("lat_valid", int'(id_out_valid), 1);
        check("lat_id", int'(id_out), 42);
        check("lat_last", int'(id_out_last), 1);
        $display("latency id=%0d valid=%0d", id_out, id_out_valid);
        step();
        check("lat_popped", int'(id_out_valid), 0);
        check("lat_id_zero", int'(id_out), 0);

        // Reset mid-operation
        id_out_ready = 1'b0;
        for (int i = 10; i <= 12; i++) begin
            id_in       = 6'(i);
            id_in_last  = 1'b0;
            id_in_valid = 1'b1;
            step();
        end
        check("pre_rst_count", int'(status_count), 3);
        sync_rst     = 1'b1;
        id_in        = 6'd13;
        id_out_ready = 1'b1;
        step();
        sync_rst     = 1'b0;
        id_in_valid  = 1'b0;
        id_out_ready = 1'b0;
        check("midrst_count", int'(status_count), 0);
        check("midrst_valid", int'(id_out_valid), 0);
        check("midrst_empty", int'(status_empty), 1);
        $display("mid reset count=%0d valid=%0d", status_count, id_out_valid);
        id_in       = 6'd7;
        id_in_valid = 1'b1;
        step();
        id_in_valid = 1'b0;
        check("post_rst_id", int'(id_out), 7);
        check("post_rst_count", int'(status_count), 1);
        id_out_ready = 1'b1;
        step();
        check("post_rst_drained", int'(id_out_valid), 0);
        $display("post reset first id=7 drained");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
